// File: rtl/spi_slave_core_if.sv
// spi_slave_core_if: configuration, stream handshakes and SPI pins of the target-side SPI engine
interface spi_slave_core_if;
  logic        en_i;
  logic        cpol_i;
  logic        cpha_i;
  logic        lsb_i;
  logic [4:0]  wlen_i;
  logic        busy_o;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [31:0] tx_data_i;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [31:0] rx_data_o;
  logic        udr_o;
  logic        ovr_o;
  logic        spi_sck_i;
  logic        spi_nss_i;
  logic        spi_mosi_i;
  logic        spi_miso_o;
  logic        spi_miso_en_o;
  modport slave (
    input  en_i, cpol_i, cpha_i, lsb_i, wlen_i, tx_valid_i, tx_data_i, rx_ready_i,
           spi_sck_i, spi_nss_i, spi_mosi_i,
    output busy_o, tx_ready_o, rx_valid_o, rx_data_o, udr_o, ovr_o, spi_miso_o, spi_miso_en_o
  );
  modport master (
    output en_i, cpol_i, cpha_i, lsb_i, wlen_i, tx_valid_i, tx_data_i, rx_ready_i,
           spi_sck_i, spi_nss_i, spi_mosi_i,
    input  busy_o, tx_ready_o, rx_valid_o, rx_data_o, udr_o, ovr_o, spi_miso_o, spi_miso_en_o
  );
endinterface

// File: rtl/spi_slave_core.sv
// spi_slave_core: oversampling SPI target, deserialises MOSI into RX words and serialises TX words onto MISO
module spi_slave_core #(
  parameter int SYNC_STAGES = 2
) (
  input logic           clk_i,
  input logic           rst_i,
  spi_slave_core_if.slave bus
);
  typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;
  state_t state, state_nx;
  logic [SYNC_STAGES-1:0] sck_s, nss_s, mosi_s;
  logic sck_q, nss_q, cpol_r, cpha_r, lsb_r;
  logic sck, nss, mosi, edge_d, lead, trail, sample, shift, done, nss_fall, busy;
  logic [4:0] wlen_r, cnt;
  logic [31:0] tx_sr, rx_sr, ld_word, src, rx_nx;
  always_comb begin
    sck = sck_s[SYNC_STAGES-1];
    nss = nss_s[SYNC_STAGES-1];
    mosi = mosi_s[SYNC_STAGES-1];
    nss_fall = nss_q & ~nss;
    edge_d = sck ^ sck_q;
    lead = edge_d & (sck ^ cpol_r);
    trail = edge_d & ~(sck ^ cpol_r);
    sample = cpha_r ? trail : lead;
    shift = cpha_r ? lead : trail;
    done = (state == XFER) && sample && (cnt == wlen_r);
    ld_word = bus.tx_valid_i ? bus.tx_data_i : '0;
    src = (state == LOAD) ? ld_word : tx_sr;
    rx_nx = lsb_r ? (rx_sr | ({31'b0, mosi} << cnt)) : {rx_sr[30:0], mosi};
    state_nx = (state != IDLE && nss) ? IDLE :
               (state == IDLE) ? ((nss_fall && bus.en_i) ? LOAD : IDLE) :
               (state == LOAD) ? XFER :
               done ? LOAD : XFER;
    busy = state != IDLE;
    bus.busy_o = busy;
    bus.spi_miso_en_o = busy;
    bus.spi_miso_o = busy & (lsb_r ? src[0] : src[wlen_r]);
    bus.tx_ready_o = (state == LOAD) & bus.tx_valid_i;
    bus.udr_o = (state == LOAD) & ~bus.tx_valid_i;
    bus.ovr_o = done & bus.rx_valid_o & ~bus.rx_ready_i;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      sck_s <= '0;
      nss_s <= '1;
      mosi_s <= '0;
      sck_q <= 1'b0;
      nss_q <= 1'b1;
      cpol_r <= 1'b0;
      cpha_r <= 1'b0;
      lsb_r <= 1'b0;
      wlen_r <= '0;
      cnt <= '0;
      tx_sr <= '0;
      rx_sr <= '0;
      bus.rx_valid_o <= 1'b0;
      bus.rx_data_o <= '0;
    end else begin
      sck_s <= {sck_s[SYNC_STAGES-2:0], bus.spi_sck_i};
      nss_s <= {nss_s[SYNC_STAGES-2:0], bus.spi_nss_i};
      mosi_s <= {mosi_s[SYNC_STAGES-2:0], bus.spi_mosi_i};
      sck_q <= sck;
      nss_q <= nss;
      state <= state_nx;
      if (state == IDLE && nss_fall && bus.en_i) begin
        cpol_r <= bus.cpol_i;
        cpha_r <= bus.cpha_i;
        lsb_r <= bus.lsb_i;
        wlen_r <= bus.wlen_i;
      end
      if (state != XFER) begin
        cnt <= '0;
        rx_sr <= '0;
      end else if (sample) begin
        cnt <= done ? 5'd0 : cnt + 5'd1;
        rx_sr <= done ? 32'd0 : rx_nx;
      end
      // no shift before a word's first sample edge: bit 0 is already on MISO from LOAD
      if (state == LOAD) tx_sr <= ld_word;
      else if (state == XFER && shift && cnt != 5'd0) tx_sr <= lsb_r ? tx_sr >> 1 : tx_sr << 1;
      if (done && (!bus.rx_valid_o || bus.rx_ready_i)) begin
        bus.rx_data_o <= rx_nx;
        bus.rx_valid_o <= 1'b1;
      end else if (bus.rx_valid_o && bus.rx_ready_i) bus.rx_valid_o <= 1'b0;
    end
  end
endmodule
